// File: rtl/dmx512_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmx_pkg                                                              |
// | Shared DMX512 transmitter constants and FSM state type.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dmx_pkg;

  localparam int DMX_MAX_SLOTS = 512;
  localparam int SLOT_AW       = 9;
  localparam int DMX_STOP_BITS = 2;
  localparam int DMX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BREAK     = 3'd1,
    MAB       = 3'd2,
    START_BIT = 3'd3,
    DATA      = 3'd4,
    STOP      = 3'd5,
    END       = 3'd6
  } dmx_state_t;

endpackage
`default_nettype wire

// File: rtl/dmx512_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmx512_tx_if                                                         |
// | Control, slot-RAM and line-side signals of the DMX512 transmitter.   |
// | Optional macro: DMX_MOD_EN adds the TX1_N/TX2_N modulated pair.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dmx512_tx_if;
  import dmx_pkg::*;

  logic               START;
  logic               CONT;
  logic [7:0]         START_CODE;
  logic [SLOT_AW-1:0] SLOT_ADDR;
  logic [7:0]         SLOT_DATA;
  logic               TX;
  logic               TX_EN;
  logic               BUSY;
  logic               DONE;
`ifdef DMX_MOD_EN
  logic               TX1_N;
  logic               TX2_N;
`endif

  modport master (
    output START, CONT, START_CODE, SLOT_DATA,
    input  SLOT_ADDR, TX, TX_EN, BUSY, DONE
`ifdef DMX_MOD_EN
    , TX1_N, TX2_N
`endif
  );

  modport slave (
    input  START, CONT, START_CODE, SLOT_DATA,
    output SLOT_ADDR, TX, TX_EN, BUSY, DONE
`ifdef DMX_MOD_EN
    , TX1_N, TX2_N
`endif
  );

endinterface
`default_nettype wire

// File: rtl/dmx512_tx_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmx_baud_tick                                                        |
// | DIV-cycle bit timer with synchronous clear and one-cycle ticks.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmx_baud_tick #(
  parameter int DIV = 48
) (
  input  wire  CLK12,
  input  wire  RST,
  input  wire  clear,
  output logic tick,
  output logic pre_tick
);

  localparam int             c_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);
  localparam logic [c_W-1:0] c_PRE  = c_W'(DIV - 2);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_W'(1);
    end
  end

  // tick marks the last cycle of a bit; pre_tick the cycle before it
  assign tick     = (r_cnt == c_LAST) && !clear;
  assign pre_tick = (r_cnt == c_PRE)  && !clear;

endmodule
`default_nettype wire

// File: rtl/dmx512_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmx512_tx                                                            |
// | DMX512 frame transmitter: BREAK, MAB, start code and SLOTS 8N2 slots.|
// | Optional macro: DMX_MOD_EN adds carrier-modulated TX1_N/TX2_N.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmx512_tx
  import dmx_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 250_000,
  parameter int SLOTS      = 512,
  parameter int BREAK_BITS = 23,
  parameter int MAB_BITS   = 3
) (
  input wire         CLK12,
  input wire         RST,
  dmx512_tx_if.slave bus
);

  localparam int              c_DIV       = CLK_HZ / BAUD;
  localparam int              c_BW        = $clog2(BREAK_BITS + MAB_BITS + DMX_DATA_BITS);
  localparam logic [c_BW-1:0] c_BRK_LAST  = c_BW'(BREAK_BITS - 1);
  localparam logic [c_BW-1:0] c_MAB_LAST  = c_BW'(MAB_BITS - 1);
  localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DMX_DATA_BITS - 1);
  localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(DMX_STOP_BITS - 1);
  localparam logic [9:0]      c_LAST_SLOT = 10'(SLOTS);

  dmx_state_t         r_state;
  logic [c_BW-1:0]    r_bit;
  logic [9:0]         r_slot;
  logic [7:0]         r_shift;
  logic [7:0]         r_code;
  logic               r_load;
  logic [SLOT_AW-1:0] r_addr;
  logic               r_tx;
  logic               r_tx_en;
  logic               r_busy;
  logic               r_done;

  logic w_clear;
  logic w_tick;
  logic w_pre_tick;

  // Holding the timer cleared while idle aligns every bit to the frame start
  assign w_clear = (r_state == IDLE);

  dmx_baud_tick #(
    .DIV (c_DIV)
  ) u_baud (
    .CLK12    (CLK12),
    .RST      (RST),
    .clear    (w_clear),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_slot  <= '0;
      r_shift <= '0;
      r_code  <= '0;
      r_load  <= 1'b0;
      r_addr  <= '0;
      r_tx    <= 1'b1;
      r_tx_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_load <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx    <= 1'b1;
          r_tx_en <= 1'b0;
          r_busy  <= 1'b0;
          if (bus.START) begin
            r_state <= BREAK;
            r_tx    <= 1'b0;
            r_tx_en <= 1'b1;
            r_busy  <= 1'b1;
            r_bit   <= '0;
            r_slot  <= '0;
            r_addr  <= '0;
            r_code  <= bus.START_CODE;
          end
        end
        BREAK: begin
          if (w_tick) begin
            if (r_bit == c_BRK_LAST) begin
              r_state <= MAB;
              r_tx    <= 1'b1;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + c_BW'(1);
            end
          end
        end
        MAB: begin
          if (w_tick) begin
            if (r_bit == c_MAB_LAST) begin
              r_state <= START_BIT;
              r_tx    <= 1'b0;
              r_load  <= 1'b1;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + c_BW'(1);
            end
          end
        end
        START_BIT: begin
          if (r_load) begin
            r_shift <= (r_slot == '0) ? r_code : bus.SLOT_DATA;
          end
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit == c_DATA_LAST) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
              r_bit   <= '0;
              // The next slot's address gets a full stop bit to settle in the RAM
              if (r_slot != c_LAST_SLOT) begin
                r_addr <= r_slot[SLOT_AW-1:0];
              end
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + c_BW'(1);
            end
          end
        end
        STOP: begin
          if (w_pre_tick && (r_bit == c_STOP_LAST) && (r_slot == c_LAST_SLOT)) begin
            r_done <= 1'b1;
          end
          if (w_tick) begin
            if (r_bit != c_STOP_LAST) begin
              r_bit <= r_bit + c_BW'(1);
            end else if (r_slot != c_LAST_SLOT) begin
              r_state <= START_BIT;
              r_tx    <= 1'b0;
              r_load  <= 1'b1;
              r_bit   <= '0;
              r_slot  <= r_slot + 10'd1;
            end else if (bus.CONT) begin
              // End of frame is resolved on this edge so chained frames have no gap
              r_state <= BREAK;
              r_tx    <= 1'b0;
              r_bit   <= '0;
              r_slot  <= '0;
              r_addr  <= '0;
              r_code  <= bus.START_CODE;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_tx_en <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_tx_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SLOT_ADDR = r_addr;
  assign bus.TX        = r_tx;
  assign bus.TX_EN     = r_tx_en;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;

`ifdef DMX_MOD_EN
  logic r_mod;

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) begin
      r_mod <= 1'b0;
    end else begin
      r_mod <= ~r_mod;
    end
  end

  assign bus.TX1_N = ~(r_tx_en & ~r_tx & r_mod);
  assign bus.TX2_N = ~(r_tx_en & ~r_tx & ~r_mod);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmx512_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmx512_tx                                                         |
// | Self-checking bench for dmx512_tx against a bit-level line model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmx512_tx;

  localparam int CLK_HZ     = 8;
  localparam int BAUD       = 1;
  localparam int SLOTS      = 4;
  localparam int BREAK_BITS = 23;
  localparam int MAB_BITS   = 3;
  localparam int DIV        = CLK_HZ / BAUD;
  localparam int FRAME      = (BREAK_BITS + MAB_BITS + 11 * (SLOTS + 1)) * DIV;
  localparam int NMAX       = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmx512_tx_if bus ();

  dmx512_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .SLOTS      (SLOTS),
    .BREAK_BITS (BREAK_BITS),
    .MAB_BITS   (MAB_BITS)
  ) dut (
    .CLK12 (clk),
    .RST   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Registered slot RAM, one cycle read latency
  logic [7:0] ram [SLOTS];
  always @(posedge clk) bus.SLOT_DATA <= ram[int'(bus.SLOT_ADDR) % SLOTS];

  int n_pass  = 0;
  int n_total = 0;

  logic       tx_tr   [NMAX];
  logic       en_tr   [NMAX];
  logic       busy_tr [NMAX];
  logic       done_tr [NMAX];
  logic [8:0] addr_tr [NMAX];
`ifdef DMX_MOD_EN
  logic       m1_tr   [NMAX];
  logic       m2_tr   [NMAX];
`endif

  logic       exp_tx   [$];
  logic [8:0] exp_addr [$];
  logic [8:0] m_addr;
  logic [7:0] ram_snap [SLOTS];

  int         hk_start    [$];
  int         hk_code_at  [$];
  logic [7:0] hk_code_val [$];
  int         hk_cont_at;
  int         hk_ram_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line model: every element of the frame expanded into DIV clock cycles
  task automatic model_bits(input logic v, input int nbits);
    repeat (nbits * DIV) begin
      exp_tx.push_back(v);
      exp_addr.push_back(m_addr);
    end
  endtask

  task automatic model_frame(input logic [7:0] code);
    logic [7:0] b;
    m_addr = '0;
    model_bits(1'b0, BREAK_BITS);
    model_bits(1'b1, MAB_BITS);
    for (int s = 0; s <= SLOTS; s++) begin
      b = (s == 0) ? code : ram_snap[s-1];
      model_bits(1'b0, 1);
      for (int j = 0; j < 8; j++) model_bits(b[j], 1);
      if (s < SLOTS) m_addr = 9'(s);
      model_bits(1'b1, 2);
    end
  endtask

  task automatic model_reset();
    exp_tx.delete();
    exp_addr.delete();
    m_addr = '0;
  endtask

  task automatic model_pad(input int n);
    while (exp_tx.size() < n) begin
      exp_tx.push_back(1'b1);
      exp_addr.push_back(m_addr);
    end
  endtask

  task automatic clear_hooks();
    hk_start.delete();
    hk_code_at.delete();
    hk_code_val.delete();
    hk_cont_at = -1;
    hk_ram_at  = -1;
  endtask

  task automatic randomize_ram();
    for (int k = 0; k < SLOTS; k++) begin
      ram[k]      = 8'($urandom);
      ram_snap[k] = ram[k];
    end
  endtask

  task automatic start_frame();
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  // Index 0 is the first BREAK cycle; sampling happens on falling edges
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tx_tr[i]   = bus.TX;
      en_tr[i]   = bus.TX_EN;
      busy_tr[i] = bus.BUSY;
      done_tr[i] = bus.DONE;
      addr_tr[i] = bus.SLOT_ADDR;
`ifdef DMX_MOD_EN
      m1_tr[i]   = bus.TX1_N;
      m2_tr[i]   = bus.TX2_N;
`endif
      bus.START = 1'b0;
      foreach (hk_start[k]) if (hk_start[k] == i) bus.START = 1'b1;
      foreach (hk_code_at[k]) if (hk_code_at[k] == i) bus.START_CODE = hk_code_val[k];
      if (i == hk_cont_at) bus.CONT = 1'b0;
      if (i == hk_ram_at) ram[0] = ~ram[0];
      @(negedge clk);
    end
  endtask

  task automatic check_waves(input string tag, input int n);
    int bad_tx;
    int bad_addr;
    bad_tx   = 0;
    bad_addr = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_tr[i] !== exp_tx[i]) bad_tx++;
      if (addr_tr[i] !== exp_addr[i]) bad_addr++;
    end
    check({tag, "_tx_wave_bad_cycles"}, bad_tx, 0);
    check({tag, "_addr_trace_bad_cycles"}, bad_addr, 0);
  endtask

  function automatic int count_high(input int sel, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0:       if (busy_tr[i] === 1'b1) c++;
        1:       if (en_tr[i] === 1'b1) c++;
        default: if (done_tr[i] === 1'b1) c++;
      endcase
    end
    return c;
  endfunction

  task automatic check_runs(input string tag);
    int r0;
    int r1;
    r0 = 0;
    while (r0 < NMAX && tx_tr[r0] === 1'b0) r0++;
    r1 = 0;
    while (r0 + r1 < NMAX && tx_tr[r0 + r1] === 1'b1) r1++;
    check({tag, "_break_cycles"}, r0, BREAK_BITS * DIV);
    check({tag, "_mab_cycles"}, r1, MAB_BITS * DIV);
  endtask

`ifdef DMX_MOD_EN
  task automatic check_mod(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < BREAK_BITS * DIV; i++) begin
      if ((m1_tr[i] & m2_tr[i]) !== 1'b0 && (m1_tr[i] | m2_tr[i]) !== 1'b1) bad++;
      if (m1_tr[i] === m2_tr[i]) bad++;
      if (i > 0 && m1_tr[i] === m1_tr[i-1]) bad++;
    end
    check({tag, "_mod_break_bad"}, bad, 0);
    bad = 0;
    for (int i = BREAK_BITS * DIV; i < n; i++) begin
      if (exp_tx[i] === 1'b1 && (m1_tr[i] !== 1'b1 || m2_tr[i] !== 1'b1)) bad++;
    end
    check({tag, "_mod_mark_bad"}, bad, 0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] codes [3];
    logic [7:0] code;

    bus.START      = 1'b0;
    bus.CONT       = 1'b0;
    bus.START_CODE = 8'h00;
    for (int k = 0; k < SLOTS; k++) ram[k] = 8'hA1 + 8'(k);
    clear_hooks();

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.TX, 1);
    check("rst_tx_en", bus.TX_EN, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_slot_addr", bus.SLOT_ADDR, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: start code 00, RAM A1..A4, stray STARTs and a late RAM write
    for (int k = 0; k < SLOTS; k++) ram_snap[k] = ram[k];
    clear_hooks();
    hk_start.push_back(50);
    hk_start.push_back(300);
    hk_start.push_back(FRAME - 1);
    hk_ram_at = 310;
    model_reset();
    model_frame(8'h00);
    model_pad(700);
    start_frame();
    capture(700);
    check_runs("f1");
    check_waves("f1", 700);
    check("f1_busy_in_frame", count_high(0, 0, FRAME - 1), FRAME);
    check("f1_txen_in_frame", count_high(1, 0, FRAME - 1), FRAME);
    check("f1_done_last_cycle", done_tr[FRAME - 1], 1);
    check("f1_done_count", count_high(2, 0, 699), 1);
    check("f1_busy_after", count_high(0, FRAME, 699), 0);
    check("f1_txen_after", count_high(1, FRAME, 699), 0);
`ifdef DMX_MOD_EN
    check_mod("f1", 700);
`endif

    // Three chained frames with CONT=1, start code changed mid-frame each time
    randomize_ram();
    for (int k = 0; k < 3; k++) codes[k] = 8'($urandom);
    clear_hooks();
    hk_code_at.push_back(100);
    hk_code_val.push_back(codes[1]);
    hk_code_at.push_back(FRAME + 100);
    hk_code_val.push_back(codes[2]);
    hk_cont_at = 2 * FRAME + 100;
    model_reset();
    for (int k = 0; k < 3; k++) model_frame(codes[k]);
    model_pad(3 * FRAME + 30);
    bus.START_CODE = codes[0];
    bus.CONT       = 1'b1;
    start_frame();
    capture(3 * FRAME + 30);
    check_waves("cont", 3 * FRAME + 30);
    check("cont_busy_held", count_high(0, 0, 3 * FRAME - 1), 3 * FRAME);
    check("cont_done_count", count_high(2, 0, 3 * FRAME + 29), 3);
    check("cont_done_f1", done_tr[FRAME - 1], 1);
    check("cont_done_f2", done_tr[2 * FRAME - 1], 1);
    check("cont_done_f3", done_tr[3 * FRAME - 1], 1);
    check("cont_no_gap_break", tx_tr[FRAME], 0);
    check("cont_busy_after", busy_tr[3 * FRAME], 0);
    bus.CONT = 1'b0;

    // Reset in the middle of slot 2 data bits
    randomize_ram();
    code = 8'($urandom);
    bus.START_CODE = code;
    clear_hooks();
    start_frame();
    capture(400);
    rst = 1'b1;
    #1;
    check("midrst_tx", bus.TX, 1);
    check("midrst_busy", bus.BUSY, 0);
    check("midrst_tx_en", bus.TX_EN, 0);
    check("midrst_done", bus.DONE, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    randomize_ram();
    code = 8'($urandom);
    bus.START_CODE = code;
    model_reset();
    model_frame(code);
    model_pad(700);
    start_frame();
    capture(700);
    check_runs("postrst");
    check_waves("postrst", 700);
    check("postrst_done_last_cycle", done_tr[FRAME - 1], 1);
    check("postrst_done_count", count_high(2, 0, 699), 1);
    check("postrst_busy_in_frame", count_high(0, 0, FRAME - 1), FRAME);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
